// File: rtl/map_ram_if.sv
// map_ram_if: tracer read port and host write port of map_ram.
//   col, row        read address (master -> slave)
//   val             registered read data (slave -> master)
//   busy            init sweep in progress (slave -> master)
//   wr_valid        write request (master -> slave)
//   wr_ready        write can be accepted (slave -> master)
//   wr_col, wr_row  write address (master -> slave)
//   wr_val          write data (master -> slave)
//   clear           one-cycle pulse restarting the init sweep (master -> slave)
interface map_ram_if #(
  parameter int MAP_WBITS = 4,
  parameter int MAP_HBITS = 4,
  parameter int VAL_BITS  = 2
);
  logic [MAP_WBITS-1:0] col;
  logic [MAP_HBITS-1:0] row;
  logic [VAL_BITS-1:0]  val;
  logic                 busy;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [MAP_WBITS-1:0] wr_col;
  logic [MAP_HBITS-1:0] wr_row;
  logic [VAL_BITS-1:0]  wr_val;
  logic                 clear;

  modport master (
    output col, row, wr_valid, wr_col, wr_row, wr_val, clear,
    input  val, busy, wr_ready
  );

  modport slave (
    input  col, row, wr_valid, wr_col, wr_row, wr_val, clear,
    output val, busy, wr_ready
  );
endinterface

// File: rtl/map_ram.sv
// map_ram: writable MAP_W x MAP_H grid of VAL_BITS-wide wall codes held in
// flops. One registered tracer read per cycle, cell updates over a
// valid/ready write port, and an init sweep after reset or clear that
// fills every cell with the default map.
//
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous, active-high
//   bus    map_ram_if.slave (read port, write port, clear, busy)
//
// Build option: MAP_RAM_DEFAULT_FILL_EN
//   defined     sweep writes the border / diagonal default pattern
//   undefined   sweep writes 0 to every cell; timing is unchanged
//
// state | meaning
// INIT  | sweep writes cell[cnt] each cycle, reads return 0, no writes accepted
// RUN   | reads served, host writes accepted
module map_ram #(
  parameter int MAP_WBITS = 4,
  parameter int MAP_HBITS = 4,
  parameter int VAL_BITS  = 2
) (
  input  logic     clk,
  input  logic     reset,
  map_ram_if.slave bus
);
  localparam int            AW    = MAP_WBITS + MAP_HBITS;
  localparam int            DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t              state;
  logic [AW-1:0]       cnt;
  logic [VAL_BITS-1:0] cells [DEPTH];
  logic [VAL_BITS-1:0] fill_val;
  logic [AW-1:0]       rd_addr;
  logic [AW-1:0]       wr_addr;
  logic                wr_accept;

  assign rd_addr   = {bus.row, bus.col};
  assign wr_addr   = {bus.wr_row, bus.wr_col};
  assign wr_accept = bus.wr_valid && bus.wr_ready;

`ifdef MAP_RAM_DEFAULT_FILL_EN
  function automatic logic [VAL_BITS-1:0] pattern(input logic [AW-1:0] a);
    int c;
    int r;
    c = int'(a[MAP_WBITS-1:0]);
    r = int'(a[AW-1:MAP_WBITS]);
    if (c == 0 || c == (1 << MAP_WBITS) - 1 || r == 0 || r == (1 << MAP_HBITS) - 1)
      return VAL_BITS'(1);
    if (c == r && c < (1 << MAP_WBITS) / 2 && r < (1 << MAP_HBITS) / 2)
      return (VAL_BITS == 1) ? VAL_BITS'(1) : VAL_BITS'(2);
    return '0;
  endfunction

  assign fill_val = pattern(cnt);
`else
  assign fill_val = '0;
`endif

  // wr_ready is only high in RUN, so sweep and host writes never collide.
  // A write landing on the same edge as clear is committed; the restarted
  // sweep overwrites it later.
  always_ff @(posedge clk) begin
    if (state == INIT)
      cells[cnt] <= fill_val;
    else if (wr_accept)
      cells[wr_addr] <= bus.wr_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= INIT;
      cnt          <= '0;
      bus.val      <= '0;
      bus.busy     <= 1'b1;
      bus.wr_ready <= 1'b0;
    end else begin
      // Read-before-write: a same-edge write to the read cell returns old data.
      bus.val <= (state == RUN) ? cells[rd_addr] : '0;
      if (bus.clear) begin
        state        <= INIT;
        cnt          <= '0;
        bus.busy     <= 1'b1;
        bus.wr_ready <= 1'b0;
      end else if (state == INIT) begin
        cnt <= cnt + AW'(1);
        if (cnt == LAST) begin
          state        <= RUN;
          bus.busy     <= 1'b0;
          bus.wr_ready <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_map_ram.sv
module tb_map_ram;
  localparam int WB = 4;
  localparam int HB = 4;
  localparam int VB = 2;

`ifdef MAP_RAM_DEFAULT_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  map_ram_if #(.MAP_WBITS(WB), .MAP_HBITS(HB), .VAL_BITS(VB)) bus ();

  map_ram #(.MAP_WBITS(WB), .MAP_HBITS(HB), .VAL_BITS(VB)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default map as described: border = 1, upper-left diagonal = 2, else 0.
  function automatic logic [31:0] dflt(input int c, input int r);
    if (!FILL) return 0;
    if (c == 0 || c == 15 || r == 0 || r == 15) return 1;
    if (c == r && c < 8) return 2;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input int c, input int r, input logic [31:0] exp);
    bus.col = 4'(c);
    bus.row = 4'(r);
    step();
    chk(tag, 32'(bus.val), exp);
  endtask

  task automatic sweep_wait(input string tag);
    repeat (255) step();
    chk({tag, "_busy_hi"},  32'(bus.busy), 1);
    chk({tag, "_ready_lo"}, 32'(bus.wr_ready), 0);
    step();
    chk({tag, "_busy_lo"},  32'(bus.busy), 0);
    chk({tag, "_ready_hi"}, 32'(bus.wr_ready), 1);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.col      = '0;
    bus.row      = '0;
    bus.wr_valid = 1'b0;
    bus.wr_col   = '0;
    bus.wr_row   = '0;
    bus.wr_val   = '0;
    bus.clear    = 1'b0;

    step();
    step();
    chk("rst_val",   32'(bus.val), 0);
    chk("rst_busy",  32'(bus.busy), 1);
    chk("rst_ready", 32'(bus.wr_ready), 0);

    // First sweep; the read presented during the last INIT cycle returns 0.
    reset   = 1'b0;
    bus.col = 4'd5;
    bus.row = 4'd5;
    sweep_wait("sweep0");
    chk("last_init_read", 32'(bus.val), 0);

    rd("rd_0_5",  0, 5,  dflt(0, 5));
    rd("rd_15_3", 15, 3, dflt(15, 3));
    rd("rd_5_5",  5, 5,  dflt(5, 5));
    rd("rd_9_9",  9, 9,  dflt(9, 9));
    rd("rd_3_2",  3, 2,  dflt(3, 2));

    // Single write in RUN.
    bus.wr_valid = 1'b1;
    bus.wr_col   = 4'd7;
    bus.wr_row   = 4'd8;
    bus.wr_val   = 2'd3;
    step();
    bus.wr_valid = 1'b0;
    rd("wr_7_8",   7, 8, 3);
    rd("wr_8_7",   8, 7, dflt(8, 7));
    chk("run_ready", 32'(bus.wr_ready), 1);

    // Same-edge read and write of (4,4).
    bus.col      = 4'd4;
    bus.row      = 4'd4;
    bus.wr_valid = 1'b1;
    bus.wr_col   = 4'd4;
    bus.wr_row   = 4'd4;
    bus.wr_val   = 2'd0;
    step();
    bus.wr_valid = 1'b0;
    chk("rw_4_4_old", 32'(bus.val), dflt(4, 4));
    step();
    chk("rw_4_4_new", 32'(bus.val), 0);

    // Clear, then clear again at sweep count 100 with a write held pending.
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("clr_busy",  32'(bus.busy), 1);
    chk("clr_ready", 32'(bus.wr_ready), 0);
    chk("clr_val",   32'(bus.val), 0);
    bus.wr_valid = 1'b1;
    bus.wr_col   = 4'd10;
    bus.wr_row   = 4'd11;
    bus.wr_val   = 2'd3;
    repeat (100) step();
    chk("pre100_busy", 32'(bus.busy), 1);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    sweep_wait("sweep1");
    step();
    bus.wr_valid = 1'b0;
    rd("held_10_11", 10, 11, 3);
    rd("restore_7_8", 7, 8, dflt(7, 8));
    rd("restore_4_4", 4, 4, dflt(4, 4));
    rd("restore_5_5", 5, 5, dflt(5, 5));

    // Writes, then reset mid-RUN with a nonzero read in flight.
    bus.wr_valid = 1'b1;
    bus.wr_col   = 4'd1;
    bus.wr_row   = 4'd1;
    bus.wr_val   = 2'd3;
    step();
    bus.wr_col   = 4'd7;
    bus.wr_row   = 4'd8;
    bus.wr_val   = 2'd1;
    step();
    bus.wr_valid = 1'b0;
    rd("pre_rst_1_1", 1, 1, 3);
    bus.col = 4'd1;
    bus.row = 4'd1;
    reset   = 1'b1;
    step();
    chk("mid_rst_val",   32'(bus.val), 0);
    chk("mid_rst_busy",  32'(bus.busy), 1);
    chk("mid_rst_ready", 32'(bus.wr_ready), 0);
    reset = 1'b0;
    sweep_wait("sweep2");
    rd("rst_1_1",   1, 1,   dflt(1, 1));
    rd("rst_7_8",   7, 8,   dflt(7, 8));
    rd("rst_10_11", 10, 11, dflt(10, 11));
    rd("rst_0_0",   0, 0,   dflt(0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
